// File: rtl/seq_det_ctrl_if.sv
// Config, control, serial-bit and status bundle for the pattern-detect controller.
// Latency: wires only.
// Backpressure: cfg_ready from the slave qualifies cfg_valid; serial bits are qualified by x_valid and never stalled.
// Ports (master = config/stream side, slave = detector):
//   cfg_valid/cfg_ready/cfg_pattern/cfg_len/cfg_overlap/cfg_target/cfg_err : configuration handshake
//   start/abort : run control;  x/x_valid : serial data
//   y/match_count/busy/done : detection status
interface seq_det_ctrl_if #(
  parameter int PAT_W = 4,
  parameter int LEN_W = 3,
  parameter int CNT_W = 8
);
  logic             cfg_valid;
  logic             cfg_ready;
  logic [PAT_W-1:0] cfg_pattern;
  logic [LEN_W-1:0] cfg_len;
  logic             cfg_overlap;
  logic [CNT_W-1:0] cfg_target;
  logic             cfg_err;
  logic             start;
  logic             abort;
  logic             x;
  logic             x_valid;
  logic             y;
  logic [CNT_W-1:0] match_count;
  logic             busy;
  logic             done;

  modport master (
    output cfg_valid, cfg_pattern, cfg_len, cfg_overlap, cfg_target,
    output start, abort, x, x_valid,
    input  cfg_ready, cfg_err, y, match_count, busy, done
  );

  modport slave (
    input  cfg_valid, cfg_pattern, cfg_len, cfg_overlap, cfg_target,
    input  start, abort, x, x_valid,
    output cfg_ready, cfg_err, y, match_count, busy, done
  );
endinterface

// File: rtl/seq_det_ctrl.sv
// Programmable serial pattern detector with IDLE/ARMED/RUN/DONE sequencing and a saturating match counter.
// Latency: y and match_count update 1 clock after the matching x_valid sample; cfg_err 1 clock after a rejected offer.
// Backpressure: cfg_ready is low only in RUN; the bit stream is never stalled (x_valid=0 cycles are simply skipped).
// Ports: clk, rst (async active-high); bus (seq_det_ctrl_if.slave) carries config handshake, start/abort,
//   x/x_valid in and y/match_count/busy/done/cfg_err out.
module seq_det_ctrl #(
  parameter int PAT_W = 4,
  parameter int LEN_W = 3,
  parameter int CNT_W = 8
) (
  input  logic          clk,
  input  logic          rst,
  seq_det_ctrl_if.slave bus
);

  typedef enum logic [1:0] {S_IDLE, S_ARMED, S_RUN, S_DONE} state_t;

  localparam logic [LEN_W:0] PAT_W_L = (LEN_W+1)'(PAT_W);

  state_t           state_q, state_d;
  // Only PAT_W-1 history bits are stored; the incoming bit completes the window.
  logic [PAT_W-2:0] hist_q, hist_d;
  logic [LEN_W-1:0] hist_cnt_q, hist_cnt_d;
  logic [PAT_W-1:0] pat_q, pat_d;
  logic [LEN_W-1:0] len_q, len_d;
  logic             ovl_q, ovl_d;
  logic [CNT_W-1:0] tgt_q, tgt_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             y_q, y_d;
  logic             err_q, err_d;

  logic             cfg_fire;
  logic             len_ok;
  logic [PAT_W-1:0] new_hist;
  logic [PAT_W-1:0] len_mask;
  logic [LEN_W:0]   hist_cnt_inc;
  logic [CNT_W-1:0] cnt_inc;
  logic             match;

  always_comb begin
    state_d    = state_q;
    hist_d     = hist_q;
    hist_cnt_d = hist_cnt_q;
    pat_d      = pat_q;
    len_d      = len_q;
    ovl_d      = ovl_q;
    tgt_d      = tgt_q;
    cnt_d      = cnt_q;
    y_d        = 1'b0;
    err_d      = 1'b0;

    cfg_fire = bus.cfg_valid && (state_q != S_RUN);
    len_ok   = (bus.cfg_len != '0) && ({1'b0, bus.cfg_len} <= PAT_W_L);
    new_hist = {hist_q, bus.x};

    // Select the low len bits of window and pattern for a variable-length compare.
    len_mask = '0;
    for (int i = 0; i < PAT_W; i++) begin
      len_mask[i] = (i < int'(len_q));
    end

    hist_cnt_inc = {1'b0, hist_cnt_q} + (LEN_W+1)'(1);
    match   = (hist_cnt_inc >= {1'b0, len_q}) && ((new_hist & len_mask) == (pat_q & len_mask));
    cnt_inc = (cnt_q == '1) ? cnt_q : cnt_q + CNT_W'(1);

    case (state_q)
      S_IDLE, S_ARMED, S_DONE: begin
        // A config offer wins over a same-cycle start, even if it is rejected.
        if (cfg_fire) begin
          if (!len_ok) begin
            err_d = 1'b1;
          end else begin
            pat_d   = bus.cfg_pattern;
            len_d   = bus.cfg_len;
            ovl_d   = bus.cfg_overlap;
            tgt_d   = bus.cfg_target;
            state_d = S_ARMED;
          end
        end else if (bus.start && (state_q != S_IDLE)) begin
          state_d    = S_RUN;
          hist_d     = '0;
          hist_cnt_d = '0;
          cnt_d      = '0;
        end
      end
      S_RUN: begin
        // abort outranks a same-cycle match: the match is dropped entirely.
        if (bus.abort) begin
          state_d = S_ARMED;
        end else if (bus.x_valid) begin
          hist_d     = new_hist[PAT_W-2:0];
          hist_cnt_d = (hist_cnt_inc > PAT_W_L) ? PAT_W_L[LEN_W-1:0] : hist_cnt_inc[LEN_W-1:0];
          if (match) begin
            y_d   = 1'b1;
            cnt_d = cnt_inc;
            // Non-overlapping mode forgets the window so the next match needs len fresh bits.
            if (!ovl_q) hist_cnt_d = '0;
            if ((tgt_q != '0) && (cnt_inc == tgt_q)) state_d = S_DONE;
          end
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= S_IDLE;
      hist_q     <= '0;
      hist_cnt_q <= '0;
      pat_q      <= '0;
      len_q      <= '0;
      ovl_q      <= 1'b0;
      tgt_q      <= '0;
      cnt_q      <= '0;
      y_q        <= 1'b0;
      err_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      hist_q     <= hist_d;
      hist_cnt_q <= hist_cnt_d;
      pat_q      <= pat_d;
      len_q      <= len_d;
      ovl_q      <= ovl_d;
      tgt_q      <= tgt_d;
      cnt_q      <= cnt_d;
      y_q        <= y_d;
      err_q      <= err_d;
    end
  end

  assign bus.cfg_ready   = (state_q != S_RUN);
  assign bus.cfg_err     = err_q;
  assign bus.y           = y_q;
  assign bus.match_count = cnt_q;
  assign bus.busy        = (state_q == S_RUN);
  assign bus.done        = (state_q == S_DONE);

endmodule
